// File: rtl/traffic_light_monitor_if.sv
// Lamp observation and monitor status bundle for traffic_light_monitor.
// master drives the lamps and clear; slave is the monitor.
interface traffic_light_monitor_if;
  logic [2:0] northSouth;
  logic [2:0] eastWest;
  logic       err_clr;
  logic       locked;
  logic [2:0] phase;
  logic       err;
  logic [2:0] err_code;
  logic [7:0] cycle_cnt;

  modport master (
    output northSouth, eastWest, err_clr,
    input  locked, phase, err, err_code, cycle_cnt
  );

  modport slave (
    input  northSouth, eastWest, err_clr,
    output locked, phase, err, err_code, cycle_cnt
  );
endinterface

// File: rtl/traffic_light_monitor.sv
// Traffic light monitor: checks NS/EW lamp patterns and phase order.
// Define TLM_DURATION_CHECK_EN to add phase-length checks (codes 4/5).
module traffic_light_monitor #(
  parameter int GREEN_CYC  = 16,
  parameter int YELLOW_CYC = 4,
  parameter int ALLRED_CYC = 4
) (
  input logic                    clk,
  input logic                    reset,
  traffic_light_monitor_if.slave mon
);

  typedef enum logic [2:0] {
    SYNC = 3'd0,
    NS_G = 3'd1,
    NS_Y = 3'd2,
    RR1  = 3'd3,
    EW_G = 3'd4,
    EW_Y = 3'd5,
    RR2  = 3'd6
  } state_e;

  localparam logic [5:0] P_NSG = 6'b001_100;
  localparam logic [5:0] P_NSY = 6'b010_100;
  localparam logic [5:0] P_RR  = 6'b100_100;
  localparam logic [5:0] P_EWG = 6'b100_001;
  localparam logic [5:0] P_EWY = 6'b100_010;

  if (GREEN_CYC < 1 || GREEN_CYC > 30 ||
      YELLOW_CYC < 1 || YELLOW_CYC > 30 ||
      ALLRED_CYC < 1 || ALLRED_CYC > 30) begin : g_bad_cfg
    $error("phase lengths must lie in 1..30");
  end

  state_e     state_q, state_d;
  state_e     succ;
  logic [5:0] prev_q, prev_d;
  logic       err_q, err_d;
  logic [2:0] code_q, code_d;
  logic [7:0] cnt_q, cnt_d;

  logic [5:0] p;
  logic [5:0] exp_p;
  logic       change;
  logic       locked;
  logic       one_hot;
  logic       legal;
  logic       short_v;
  logic       over_v;
  logic [2:0] viol;

  assign p       = {mon.northSouth, mon.eastWest};
  assign change  = p != prev_q;
  assign locked  = state_q != SYNC;
  assign one_hot = $onehot(mon.northSouth) && $onehot(mon.eastWest);
  assign legal   = p inside {P_NSG, P_NSY, P_RR, P_EWG, P_EWY};

  always_comb begin
    succ  = SYNC;
    exp_p = P_NSG;
    unique case (state_q)
      NS_G: begin succ = NS_Y; exp_p = P_NSY; end
      NS_Y: begin succ = RR1;  exp_p = P_RR;  end
      RR1:  begin succ = EW_G; exp_p = P_EWG; end
      EW_G: begin succ = EW_Y; exp_p = P_EWY; end
      EW_Y: begin succ = RR2;  exp_p = P_RR;  end
      RR2:  begin succ = NS_G; exp_p = P_NSG; end
      default: ;
    endcase
  end

`ifdef TLM_DURATION_CHECK_EN
  logic [4:0] run_q, run_d;
  logic [4:0] req_len;

  always_comb begin
    unique case (state_q)
      NS_G, EW_G: req_len = 5'(GREEN_CYC);
      NS_Y, EW_Y: req_len = 5'(YELLOW_CYC);
      default:    req_len = 5'(ALLRED_CYC);
    endcase
  end

  // run counts consecutive samples of prev_q's pattern
  always_comb begin
    run_d = run_q + 5'd1;
    if (change) run_d = 5'd1;
    else if (run_q == 5'd31) run_d = run_q;
  end

  assign short_v = change && (run_q < req_len);
  assign over_v  = !change && (run_q >= req_len);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) run_q <= 5'd0;
    else        run_q <= run_d;
  end
`else
  assign short_v = 1'b0;
  assign over_v  = 1'b0;
`endif

  // lowest violation code wins
  always_comb begin
    viol = 3'd0;
    priority case (1'b1)
      !one_hot:                             viol = 3'd1;
      !legal:                               viol = 3'd2;
      locked && change && (p != exp_p):     viol = 3'd3;
      locked && short_v:                    viol = 3'd4;
      locked && over_v:                     viol = 3'd5;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    prev_d  = p;
    err_d   = err_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    if (viol != 3'd0) begin
      state_d = SYNC;
    end else if (!locked) begin
      if (p == P_NSG && prev_q != P_NSG) state_d = NS_G;
    end else if (change) begin
      state_d = succ;
      if (state_q == RR2) cnt_d = cnt_q + 8'd1;
    end
    if (mon.err_clr) begin
      err_d  = 1'b0;
      code_d = 3'd0;
    end
    if (viol != 3'd0 && (!err_q || mon.err_clr)) begin
      err_d  = 1'b1;
      code_d = viol;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= SYNC;
      prev_q  <= 6'd0;
      err_q   <= 1'b0;
      code_q  <= 3'd0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      err_q   <= err_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mon.locked    = locked;
  assign mon.phase     = state_q;
  assign mon.err       = err_q;
  assign mon.err_code  = code_q;
  assign mon.cycle_cnt = cnt_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Testbench for traffic_light_monitor: directed scenarios plus a
// randomized phase walk scored against a phase-table reference model.
module tb_traffic_light_monitor;

  localparam int G = 16;
  localparam int Y = 4;
  localparam int A = 4;
`ifdef TLM_DURATION_CHECK_EN
  localparam bit DUR = 1'b1;
`else
  localparam bit DUR = 1'b0;
`endif

  localparam logic [5:0] NSG = 6'b001_100;
  localparam logic [5:0] NSY = 6'b010_100;
  localparam logic [5:0] RR  = 6'b100_100;
  localparam logic [5:0] EWG = 6'b100_001;
  localparam logic [5:0] EWY = 6'b100_010;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  traffic_light_monitor_if bus ();

  traffic_light_monitor #(
    .GREEN_CYC  (G),
    .YELLOW_CYC (Y),
    .ALLRED_CYC (A)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .mon   (bus)
  );

  // phase table: index 1..6 = NS_G NS_Y RR1 EW_G EW_Y RR2
  logic [5:0] pat [0:6] = '{6'd0, NSG, NSY, RR, EWG, EWY, RR};
  int         len [0:6] = '{0, G, Y, A, G, Y, A};

  int         m_ph;
  logic [5:0] m_prev;
  int         m_run;
  bit         m_err;
  int         m_code;
  int         m_cnt;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic bit is_legal(logic [5:0] p);
    for (int i = 1; i <= 5; i++)
      if (pat[i] == p) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_ph   = 0;
    m_prev = 6'd0;
    m_run  = 0;
    m_err  = 1'b0;
    m_code = 0;
    m_cnt  = 0;
  endtask

  task automatic model(logic [5:0] p, bit clr);
    bit ch;
    int code;
    int nx;
    ch   = (p != m_prev);
    nx   = m_ph % 6 + 1;
    code = 0;
    if (!$onehot(p[5:3]) || !$onehot(p[2:0])) code = 1;
    else if (!is_legal(p)) code = 2;
    else if (m_ph != 0) begin
      if (ch && p != pat[nx]) code = 3;
      else if (DUR && ch && m_run < len[m_ph]) code = 4;
      else if (DUR && !ch && m_run + 1 > len[m_ph]) code = 5;
    end
    if (code != 0 && (!m_err || clr)) begin
      m_err  = 1'b1;
      m_code = code;
    end else if (clr) begin
      m_err  = 1'b0;
      m_code = 0;
    end
    if (code != 0) m_ph = 0;
    else if (m_ph == 0) begin
      if (p == NSG && m_prev != NSG) m_ph = 1;
    end else if (ch) begin
      if (m_ph == 6) m_cnt = (m_cnt + 1) % 256;
      m_ph = nx;
    end
    m_run  = ch ? 1 : (m_run < 31 ? m_run + 1 : 31);
    m_prev = p;
  endtask

  task automatic compare();
    chk("phase", bus.phase, m_ph);
    chk("locked", bus.locked, m_ph != 0);
    chk("err", bus.err, m_err);
    chk("err_code", bus.err_code, m_code);
    chk("cycle_cnt", bus.cycle_cnt, m_cnt);
  endtask

  task automatic step(logic [5:0] p, bit clr);
    bus.northSouth = p[5:3];
    bus.eastWest   = p[2:0];
    bus.err_clr    = clr;
    @(posedge clk);
    model(p, clr);
    #1;
    compare();
  endtask

  task automatic hold(logic [5:0] p, int n);
    for (int i = 0; i < n; i++) step(p, 1'b0);
  endtask

  task automatic cycles(int n);
    for (int c = 0; c < n; c++)
      for (int k = 1; k <= 6; k++) hold(pat[k], len[k]);
  endtask

  // force SYNC, then relock on one NS_G sample with err cleared
  task automatic resync();
    step(6'd0, 1'b0);
    hold(RR, A);
    step(NSG, 1'b1);
  endtask

  initial begin
    int k;
    int n;
    int r;
    logic [5:0] p;
    bus.northSouth = 3'd0;
    bus.eastWest   = 3'd0;
    bus.err_clr    = 1'b0;
    model_reset();
    #1 rst_n = 1'b0;
    #5;
    chk("rst_phase", bus.phase, 0);
    chk("rst_locked", bus.locked, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_code", bus.err_code, 0);
    chk("rst_cnt", bus.cycle_cnt, 0);
    #1 rst_n = 1'b1;

    step(NSG, 1'b0);
    chk("lock_first", bus.locked, 1);
    hold(NSG, G - 1);
    for (int k2 = 2; k2 <= 6; k2++) hold(pat[k2], len[k2]);
    cycles(2);
    step(NSG, 1'b0);
    chk("three_cycles", bus.cycle_cnt, 3);
    chk("legal_no_err", bus.err, 0);

    hold(NSG, G - 2);
    hold(NSY, Y);
    hold(RR, A);
    hold(EWG, 5);
    step(6'b001_001, 1'b0);
    chk("glitch_code", bus.err_code, 2);
    chk("glitch_phase", bus.phase, 0);
    hold(EWG, 10);
    hold(EWY, Y);
    hold(RR, A);
    step(NSG, 1'b1);
    chk("relock", bus.locked, 1);

    hold(NSG, G - 1);
    hold(NSY, Y - 1);
    step(RR, 1'b0);
    chk("short_yellow", bus.err_code, DUR ? 4 : 0);

    resync();
    hold(NSG, G);
    chk("green_over", bus.err_code, DUR ? 5 : 0);

    resync();
    hold(NSG, G - 1);
    step(RR, 1'b0);
    chk("skip_nsy", bus.err_code, 3);

    resync();
    hold(NSG, G - 1);
    hold(NSY, 2);
    step(6'b011_100, 1'b0);
    chk("code1_wins", bus.err_code, 1);
    step(6'b001_001, 1'b1);
    chk("clr_vs_new_err", bus.err, 1);
    chk("clr_vs_new_code", bus.err_code, 2);

    resync();
    hold(NSG, G - 1);
    k = 2;
    for (int it = 0; it < 80; it++) begin
      n = len[k];
      r = $urandom_range(0, 9);
      if (r == 0) n = n - 1;
      else if (r == 1) n = n + 1;
      for (int s = 0; s < n; s++) begin
        p = pat[k];
        if ($urandom_range(0, 39) == 0) p = 6'($urandom_range(0, 63));
        step(p, $urandom_range(0, 7) == 0);
      end
      if ($urandom_range(0, 19) == 0) k = (k + 1) % 6 + 1;
      else k = k % 6 + 1;
    end

    resync();
    hold(NSG, 5);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_phase", bus.phase, 0);
    chk("async_locked", bus.locked, 0);
    chk("async_err", bus.err, 0);
    chk("async_code", bus.err_code, 0);
    chk("async_cnt", bus.cycle_cnt, 0);
    #1 rst_n = 1'b1;

    cycles(255);
    step(NSG, 1'b0);
    chk("cnt_255", bus.cycle_cnt, 255);
    hold(NSG, G - 1);
    for (int k3 = 2; k3 <= 6; k3++) hold(pat[k3], len[k3]);
    step(NSG, 1'b0);
    chk("cnt_wrap", bus.cycle_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
